// File: rtl/fp_posit_mul_vec.sv
// rtl/fp_posit_mul_vec.sv - multi-lane FP x bit-serial posit multiplier (option: FP_POSIT_MUL_SUBNORM_EN)
module fp_posit_mul_vec #(
    parameter int LANES     = 4,
    parameter int EXP_WIDTH = 5,
    parameter int MAN_WIDTH = 10,
    parameter int MAX_PREC  = 8,
    parameter int ES_MAX    = 2,
    localparam int ACT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH,
    localparam int FRAC_W    = MAX_PREC - 3,
    localparam int OEW       = EXP_WIDTH + 3,
    localparam int MW        = MAN_WIDTH + FRAC_W + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_set,
    input  logic [3:0]             cfg_prec,
    input  logic [1:0]             cfg_es,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ACT_WIDTH-1:0]   act,
    input  logic [LANES-1:0]       w,
    input  logic                   w_valid,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       sign_out,
    output logic [LANES*OEW-1:0]   exp_out,
    output logic [LANES*MW-1:0]    mant_out,
    output logic [LANES-1:0]       zero_out,
    output logic [LANES-1:0]       nar_out
);

    localparam int KW  = $clog2(MAX_PREC) + 1;
    localparam int FIW = $clog2(FRAC_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    localparam logic [1:0] P_R0 = 2'd0, P_RUN = 2'd1, P_EXP = 2'd2, P_FRAC = 2'd3;

    state_t               state, state_nx;
    logic [3:0]           prec_r, cnt, prec_cl;
    logic [1:0]           es_r, es_cl;
    logic                 act_s;
    logic [EXP_WIDTH-1:0] exp_eff_r, exp_eff_in, act_exp;
    logic [MW-1:0]        base_r, base_in;
    logic                 hid_in, start, beat;

    logic                 sgn  [LANES];
    logic                 rbit [LANES];
    logic                 nz   [LANES];
    logic [1:0]           ph   [LANES];
    logic [1:0]           ecnt [LANES];
    logic [KW-1:0]        k_r  [LANES];
    logic [ES_MAX-1:0]    ev   [LANES];
    logic [FIW-1:0]       fidx [LANES];
    logic [MW-1:0]        acc  [LANES];

    assign start   = in_valid & in_ready;
    assign beat    = (state == S_BUSY) & w_valid;
    assign act_exp = act[ACT_WIDTH-2 -: EXP_WIDTH];

    // Clamp requested configuration into the supported range
    always_comb begin
        prec_cl = cfg_prec;
        if (cfg_prec < 4'd3)
            prec_cl = 4'd3;
        else if (cfg_prec > 4'(MAX_PREC))
            prec_cl = 4'(MAX_PREC);
        es_cl = (cfg_es > 2'(ES_MAX)) ? 2'(ES_MAX) : cfg_es;
    end

    // Activation hidden bit, effective exponent and the shifted 1.f base term
    always_comb begin
`ifdef FP_POSIT_MUL_SUBNORM_EN
        hid_in     = |act_exp;
        exp_eff_in = hid_in ? act_exp : EXP_WIDTH'(1);
`else
        hid_in     = 1'b1;
        exp_eff_in = act_exp;
`endif
        base_in = MW'({hid_in, act[MAN_WIDTH-1:0]}) << FRAC_W;
    end

    // Word-level state register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Word-level next state: shared beat counter ends the word after n beats
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (in_valid) state_nx = S_BUSY;
            S_BUSY: if (w_valid && cnt == prec_r - 4'd1) state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = in_valid ? S_BUSY : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Configuration, beat counter and per-word activation capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            prec_r    <= 4'(MAX_PREC);
            es_r      <= 2'd0;
            cnt       <= 4'd0;
            act_s     <= 1'b0;
            exp_eff_r <= '0;
            base_r    <= '0;
        end else begin
            if (cfg_set && state == S_IDLE) begin
                prec_r <= prec_cl;
                es_r   <= es_cl;
            end
            if (start) begin
                cnt       <= 4'd1;
                act_s     <= act[ACT_WIDTH-1];
                exp_eff_r <= exp_eff_in;
                base_r    <= base_in;
            end else if (beat) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Per-lane bit-serial posit decode and mantissa accumulation
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (!rst) begin
                sgn[i] <= 1'b0; rbit[i] <= 1'b0; nz[i] <= 1'b0; ph[i] <= P_R0;
                ecnt[i] <= 2'd0; k_r[i] <= '0; ev[i] <= '0; fidx[i] <= '0; acc[i] <= '0;
            end else if (start) begin
                sgn[i]  <= w[i];
                nz[i]   <= 1'b0;
                ph[i]   <= P_R0;
                ecnt[i] <= 2'd0;
                k_r[i]  <= '0;
                ev[i]   <= '0;
                fidx[i] <= FIW'(1);
                acc[i]  <= base_in;
            end else if (beat) begin
                nz[i] <= nz[i] | w[i];
                case (ph[i])
                    P_R0: begin
                        rbit[i] <= w[i];
                        k_r[i]  <= w[i] ? '0 : '1;
                        ph[i]   <= P_RUN;
                    end
                    P_RUN: begin
                        if (w[i] == rbit[i])
                            k_r[i] <= rbit[i] ? k_r[i] + KW'(1) : k_r[i] - KW'(1);
                        else
                            ph[i] <= (es_r == 2'd0) ? P_FRAC : P_EXP;
                    end
                    P_EXP: begin
                        ev[i]   <= ev[i] | (ES_MAX'(w[i]) << (es_r - 2'd1 - ecnt[i]));
                        ecnt[i] <= ecnt[i] + 2'd1;
                        if (ecnt[i] + 2'd1 == es_r)
                            ph[i] <= P_FRAC;
                    end
                    default: begin
                        if (w[i])
                            acc[i] <= acc[i] + (base_r >> fidx[i]);
                        fidx[i] <= fidx[i] + FIW'(1);
                    end
                endcase
            end
        end
    end

    // Handshake and result outputs; data is forced to 0 outside DONE
    always_comb begin
        logic [OEW-1:0] kx;
        logic [OEW-1:0] ex;
        logic           done;
        kx        = '0;
        ex        = '0;
        done      = (state == S_DONE);
        in_ready  = rst & ((state == S_IDLE) | (done & out_ready));
        out_valid = done;
        sign_out  = '0;
        exp_out   = '0;
        mant_out  = '0;
        zero_out  = '0;
        nar_out   = '0;
        for (int i = 0; i < LANES; i++) begin
            kx = {{(OEW-KW){k_r[i][KW-1]}}, k_r[i]};
            ex = OEW'(exp_eff_r) + (kx << es_r) + OEW'(ev[i]);
            if (done) begin
                if (nz[i]) begin
                    sign_out[i]            = sgn[i] ^ act_s;
                    exp_out[i*OEW +: OEW]  = ex;
                    mant_out[i*MW +: MW]   = acc[i];
                end else begin
                    sign_out[i] = sgn[i];
                    zero_out[i] = ~sgn[i];
                    nar_out[i]  = sgn[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_posit_mul_vec.sv
// tb/tb_fp_posit_mul_vec.sv - randomized self-checking bench for fp_posit_mul_vec
module tb_fp_posit_mul_vec;

    localparam int LANES = 4;
    localparam int OEW   = 8;
    localparam int MW    = 17;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_set;
    logic [3:0]           cfg_prec;
    logic [1:0]           cfg_es;
    logic                 in_valid;
    logic                 in_ready;
    logic [15:0]          act;
    logic [LANES-1:0]     w;
    logic                 w_valid;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES-1:0]     sign_out;
    logic [LANES*OEW-1:0] exp_out;
    logic [LANES*MW-1:0]  mant_out;
    logic [LANES-1:0]     zero_out;
    logic [LANES-1:0]     nar_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_n    = 8;
    int cur_es   = 0;

    always #5 clk = ~clk;

    fp_posit_mul_vec dut (
        .clk(clk), .rst(rst), .cfg_set(cfg_set), .cfg_prec(cfg_prec), .cfg_es(cfg_es),
        .in_valid(in_valid), .in_ready(in_ready), .act(act), .w(w), .w_valid(w_valid),
        .out_valid(out_valid), .out_ready(out_ready), .sign_out(sign_out), .exp_out(exp_out),
        .mant_out(mant_out), .zero_out(zero_out), .nar_out(nar_out)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: decode an n-bit sign-magnitude posit and multiply with plain arithmetic
    task automatic ref_lane(input logic [15:0] a, input int wv, input int n, input int es,
                            output logic s, output logic [OEW-1:0] ex, output logic [MW-1:0] mt,
                            output logic z, output logic nr);
        int sg, nb, body, pos, r, m, k, e, got, nf, f, ae, hid, prod;
        sg   = (wv >> (n - 1)) & 1;
        nb   = n - 1;
        body = wv & ((1 << nb) - 1);
        ae   = int'(a[14:10]);
        hid  = 1;
`ifdef FP_POSIT_MUL_SUBNORM_EN
        if (ae == 0) begin
            ae  = 1;
            hid = 0;
        end
`endif
        if (body == 0) begin
            s = sg[0]; z = ~sg[0]; nr = sg[0]; ex = '0; mt = '0;
            return;
        end
        pos = nb - 1;
        r   = (body >> pos) & 1;
        m   = 0;
        while (pos >= 0 && ((body >> pos) & 1) == r) begin
            m++;
            pos--;
        end
        if (pos >= 0) pos--;
        k   = (r == 1) ? m - 1 : -m;
        e   = 0;
        got = 0;
        while (got < es && pos >= 0) begin
            e = e * 2 + ((body >> pos) & 1);
            got++;
            pos--;
        end
        e    = e << (es - got);
        nf   = pos + 1;
        f    = body & ((1 << nf) - 1);
        prod = ((hid << 10) | int'(a[9:0])) * (32 + (f << (5 - nf)));
        mt   = prod[MW-1:0];
        prod = ae + k * (1 << es) + e;
        ex   = prod[OEW-1:0];
        s    = sg[0] ^ a[15];
        z    = 1'b0;
        nr   = 1'b0;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
    endtask

    task automatic run_word(input logic [15:0] a, input logic [31:0] wpk, input bit do_cfg,
                            input int cp, input int ce, input int gap_pct, input int hold);
        logic [LANES-1:0]     e_s, e_z, e_n;
        logic [LANES*OEW-1:0] e_x;
        logic [LANES*MW-1:0]  e_m;
        logic                 s1, z1, n1;
        logic [OEW-1:0]       x1;
        logic [MW-1:0]        m1;
        int                   wv [LANES];
        wait_ready();
        if (do_cfg) begin
            cfg_set  = 1'b1;
            cfg_prec = cp[3:0];
            cfg_es   = ce[1:0];
            cur_n    = (cp < 3) ? 3 : (cp > 8 ? 8 : cp);
            cur_es   = (ce > 2) ? 2 : ce;
        end
        for (int l = 0; l < LANES; l++) begin
            wv[l] = int'(wpk[l*8 +: 8]) & ((1 << cur_n) - 1);
            ref_lane(a, wv[l], cur_n, cur_es, s1, x1, m1, z1, n1);
            e_s[l] = s1; e_z[l] = z1; e_n[l] = n1;
            e_x[l*OEW +: OEW] = x1;
            e_m[l*MW +: MW]   = m1;
        end
        in_valid = 1'b1;
        act      = a;
        for (int l = 0; l < LANES; l++) w[l] = wv[l][cur_n-1];
        tick();
        in_valid = 1'b0;
        cfg_set  = 1'b0;
        act      = 16'($urandom);
        for (int b = cur_n - 2; b >= 0; b--) begin
            for (int g = 0; g < 3; g++) begin
                if (int'($urandom_range(99)) < gap_pct) begin
                    w_valid  = 1'b0;
                    w        = 4'($urandom);
                    cfg_set  = 1'($urandom);
                    cfg_prec = 4'($urandom);
                    cfg_es   = 2'($urandom);
                    tick();
                    cfg_set  = 1'b0;
                end
            end
            w_valid = 1'b1;
            for (int l = 0; l < LANES; l++) w[l] = wv[l][b];
            tick();
        end
        w_valid = 1'b0;
        check("out_valid_latency", out_valid, 1'b1);
        for (int h = 0; h <= hold; h++) begin
            check("sign_out", sign_out, e_s);
            check("exp_out", exp_out, e_x);
            check("mant_out", mant_out, e_m);
            check("zero_out", zero_out, e_z);
            check("nar_out", nar_out, e_n);
            if (h < hold) begin
                check("in_ready_hold", in_ready, 1'b0);
                w_valid = 1'($urandom);
                w       = 4'($urandom);
                tick();
                check("out_valid_hold", out_valid, 1'b1);
            end
        end
        w_valid   = 1'b0;
        out_ready = 1'b1;
        #1;
        check("in_ready_drain", in_ready, 1'b1);
        tick();
        out_ready = 1'b0;
        check("out_valid_drained", out_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b0; cfg_set = 1'b0; cfg_prec = 4'd0; cfg_es = 2'd0; in_valid = 1'b0;
        act = 16'd0; w = '0; w_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outputs", {sign_out, exp_out, mant_out, zero_out, nar_out}, '0);
        rst = 1'b1;
        tick();

        // Directed: unity, regime k=1, signed, zero / NaR lanes, es=1 case
        run_word(16'h3C00, 32'h00E0_6040, 1'b1, 8, 0, 0, 0);
        run_word(16'h3E00, 32'h7F40_8050, 1'b0, 0, 0, 40, 5);
        run_word(16'h3C00, 32'hFF80_0018, 1'b1, 8, 1, 0, 2);
        run_word(16'h0200, 32'h4060_7F01, 1'b1, 8, 0, 30, 1);
        run_word(16'hBC00, 32'h7F7E_0102, 1'b1, 15, 3, 0, 0);

        // Reset in the middle of a word discards it
        wait_ready();
        in_valid = 1'b1;
        act      = 16'h3C00;
        w        = 4'b1010;
        tick();
        in_valid = 1'b0;
        w_valid  = 1'b1;
        repeat (3) tick();
        rst     = 1'b0;
        w_valid = 1'b0;
        tick();
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_outputs", {sign_out, exp_out, mant_out, zero_out, nar_out}, '0);
        rst    = 1'b1;
        cur_n  = 8;
        cur_es = 0;
        repeat (10) tick();
        check("midrst_no_result", out_valid, 1'b0);
        run_word(16'h3E00, 32'h50E0_6040, 1'b0, 0, 0, 0, 0);

        // Randomized words with random configuration, stalls and back-pressure
        for (int t = 0; t < 60; t++) begin
            run_word(16'($urandom), $urandom, 1'($urandom), int'($urandom_range(15)),
                     int'($urandom_range(3)), int'($urandom_range(50)), int'($urandom_range(5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
